// File: rtl/strela_cg_pkg.sv
// Shared types and default timing constants for the STRELA CGRA clock-gate controller.
package strela_cg_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_GATED = 2'd1,
    ST_WAKE  = 2'd2
  } cg_state_e;

  localparam int DEFAULT_IDLE_CYCLES = 16;
  localparam int DEFAULT_WAKE_CYCLES = 2;

endpackage

// File: rtl/strela_cg_stats.sv
// Free-running 32-bit counter of cycles spent with the CGRA clock gated off.
module strela_cg_stats (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        inc_i,
  output logic [31:0] count_o
);

  logic [31:0] count_q;

  // A clear always beats an increment; the counter wraps naturally at 2^32.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      count_q <= '0;
    end else if (inc_i) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/strela_clk_gate_ctrl.sv
// Idle-driven clock-gate controller for the STRELA CGRA (RUN / GATED / WAKE).
// Define STRELA_CG_STATS_EN to build the gated-cycle statistics counter.
module strela_clk_gate_ctrl
  import strela_cg_pkg::*;
#(
  parameter int IDLE_CYCLES = DEFAULT_IDLE_CYCLES,
  parameter int WAKE_CYCLES = DEFAULT_WAKE_CYCLES
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cg_enable_i,
  input  logic        force_en_i,
  input  logic        busy_i,
  input  logic        wake_req_i,
  output logic        wake_ack_o,
  output logic        en_o,
  output logic        gated_o,
  output logic [31:0] gated_cycles_o,
  input  logic        stats_clr_i
);

  localparam int ICW = (IDLE_CYCLES > 0) ? $clog2(IDLE_CYCLES + 1) : 1;
  localparam int WCW = (WAKE_CYCLES > 0) ? $clog2(WAKE_CYCLES + 1) : 1;

  localparam bit             GATE_EN   = (IDLE_CYCLES != 0);
  localparam logic [ICW-1:0] IDLE_LAST = ICW'(IDLE_CYCLES - 1);
  localparam logic [ICW-1:0] IDLE_MAX  = ICW'(IDLE_CYCLES);
  localparam logic [ICW-1:0] IDLE_ONE  = ICW'(1);
  localparam logic [WCW-1:0] WAKE_LAST = WCW'(WAKE_CYCLES - 1);
  localparam logic [WCW-1:0] WAKE_ONE  = WCW'(1);

  cg_state_e      state_q;
  logic           en_q;
  logic [ICW-1:0] idle_cnt_q;
  logic [WCW-1:0] wake_cnt_q;
  logic           wake_ack_q;
  logic           ack_armed_q;

  logic idle_cycle;
  logic wake_event;

  assign idle_cycle = !busy_i && !wake_req_i && cg_enable_i;
  assign wake_event = busy_i || wake_req_i || !cg_enable_i;

  // The ack is re-armed only by seeing the request low, so a held request
  // produces exactly one pulse; requests seen in GATED/WAKE are answered
  // on the WAKE->RUN edge, i.e. in the first RUN cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_RUN;
      en_q        <= 1'b1;
      idle_cnt_q  <= '0;
      wake_cnt_q  <= '0;
      wake_ack_q  <= 1'b0;
      ack_armed_q <= 1'b1;
    end else begin
      wake_ack_q <= 1'b0;
      if (!wake_req_i) begin
        ack_armed_q <= 1'b1;
      end
      case (state_q)
        ST_RUN: begin
          if (wake_req_i && ack_armed_q) begin
            wake_ack_q  <= 1'b1;
            ack_armed_q <= 1'b0;
          end
          if (!idle_cycle) begin
            idle_cnt_q <= '0;
          end else if (GATE_EN && (idle_cnt_q == IDLE_LAST)) begin
            state_q    <= ST_GATED;
            en_q       <= 1'b0;
            idle_cnt_q <= '0;
          end else if (idle_cnt_q != IDLE_MAX) begin
            idle_cnt_q <= idle_cnt_q + IDLE_ONE;
          end
        end
        ST_GATED: begin
          if (wake_event) begin
            state_q    <= ST_WAKE;
            en_q       <= 1'b1;
            wake_cnt_q <= '0;
          end
        end
        ST_WAKE: begin
          if (wake_cnt_q == WAKE_LAST) begin
            state_q    <= ST_RUN;
            idle_cnt_q <= '0;
            wake_cnt_q <= '0;
            if (wake_req_i && ack_armed_q) begin
              wake_ack_q  <= 1'b1;
              ack_armed_q <= 1'b0;
            end
          end else begin
            wake_cnt_q <= wake_cnt_q + WAKE_ONE;
          end
        end
        default: begin
          state_q    <= ST_RUN;
          en_q       <= 1'b1;
          idle_cnt_q <= '0;
          wake_cnt_q <= '0;
        end
      endcase
    end
  end

  assign en_o       = en_q || force_en_i;
  assign gated_o    = (state_q == ST_GATED);
  assign wake_ack_o = wake_ack_q;

`ifdef STRELA_CG_STATS_EN
  strela_cg_stats u_stats (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (stats_clr_i),
    .inc_i   (!en_q),
    .count_o (gated_cycles_o)
  );
`else
  logic unused_stats_clr;
  assign unused_stats_clr = stats_clr_i;
  assign gated_cycles_o   = '0;
`endif

endmodule

// File: tb/tb_strela_clk_gate_ctrl.sv
// Directed self-checking bench for strela_clk_gate_ctrl (defaults IDLE_CYCLES=16, WAKE_CYCLES=2).
// Stats expectations follow STRELA_CG_STATS_EN when it is defined for the build.
module tb_strela_clk_gate_ctrl;

`ifdef STRELA_CG_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        cg_enable_i;
  logic        force_en_i;
  logic        busy_i;
  logic        wake_req_i;
  logic        wake_ack_o;
  logic        en_o;
  logic        gated_o;
  logic [31:0] gated_cycles_o;
  logic        stats_clr_i;

  int checks = 0;
  int errors = 0;

  strela_clk_gate_ctrl dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .cg_enable_i    (cg_enable_i),
    .force_en_i     (force_en_i),
    .busy_i         (busy_i),
    .wake_req_i     (wake_req_i),
    .wake_ack_o     (wake_ack_o),
    .en_o           (en_o),
    .gated_o        (gated_o),
    .gated_cycles_o (gated_cycles_o),
    .stats_clr_i    (stats_clr_i)
  );

  always #5 clk_i = ~clk_i;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  function automatic logic [31:0] stat_exp(input logic [31:0] n);
    return STATS ? n : 32'd0;
  endfunction

  // Leaves the DUT in RUN with idle counter 0 and busy still high.
  task automatic apply_reset();
    rst_i       = 1'b1;
    cg_enable_i = 1'b1;
    force_en_i  = 1'b0;
    busy_i      = 1'b1;
    wake_req_i  = 1'b0;
    stats_clr_i = 1'b0;
    step(2);
    rst_i = 1'b0;
  endtask

  // Reset, then 16 idle cycles; returns with the DUT just entered GATED.
  task automatic reach_gated();
    apply_reset();
    busy_i = 1'b0;
    step(16);
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (en_o !== 1'b1) begin errors++; $display("[TB] FAIL reset_en: got %b expected 1", en_o); end
    checks++;
    if (gated_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_gated: got %b expected 0", gated_o); end
    checks++;
    if (wake_ack_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_ack: got %b expected 0", wake_ack_o); end
    checks++;
    if (gated_cycles_o !== 32'd0) begin errors++; $display("[TB] FAIL reset_stats: got %0h expected 0", gated_cycles_o); end
  endtask

  task automatic test_idle_gating();
    apply_reset();
    busy_i = 1'b0;
    step(15);
    checks++;
    if (en_o !== 1'b1 || gated_o !== 1'b0) begin
      errors++; $display("[TB] FAIL idle15: got en=%b gated=%b expected en=1 gated=0", en_o, gated_o);
    end
    step(1);
    checks++;
    if (en_o !== 1'b0 || gated_o !== 1'b1) begin
      errors++; $display("[TB] FAIL idle16_gate: got en=%b gated=%b expected en=0 gated=1", en_o, gated_o);
    end
    step(3);
    checks++;
    if (gated_cycles_o !== stat_exp(32'd3)) begin
      errors++; $display("[TB] FAIL gated_count: got %0d expected %0d", gated_cycles_o, stat_exp(32'd3));
    end
  endtask

  task automatic test_threshold_override();
    apply_reset();
    busy_i = 1'b0;
    step(15);
    busy_i = 1'b1;
    step(1);
    checks++;
    if (en_o !== 1'b1 || gated_o !== 1'b0) begin
      errors++; $display("[TB] FAIL busy_threshold: got en=%b gated=%b expected en=1 gated=0", en_o, gated_o);
    end
    busy_i = 1'b0;
    step(15);
    checks++;
    if (en_o !== 1'b1) begin errors++; $display("[TB] FAIL counter_cleared: got en=%b expected 1", en_o); end
    step(1);
    checks++;
    if (en_o !== 1'b0) begin errors++; $display("[TB] FAIL regate: got en=%b expected 0", en_o); end
    apply_reset();
    busy_i = 1'b0;
    step(15);
    wake_req_i = 1'b1;
    step(1);
    checks++;
    if (en_o !== 1'b1 || wake_ack_o !== 1'b1) begin
      errors++; $display("[TB] FAIL req_threshold: got en=%b ack=%b expected en=1 ack=1", en_o, wake_ack_o);
    end
    wake_req_i = 1'b0;
  endtask

  task automatic test_wake_request();
    int pulses;
    reach_gated();
    wake_req_i = 1'b1;
    step(1);
    checks++;
    if (en_o !== 1'b1 || gated_o !== 1'b0 || wake_ack_o !== 1'b0) begin
      errors++; $display("[TB] FAIL wake_c1: got en=%b gated=%b ack=%b expected 1 0 0", en_o, gated_o, wake_ack_o);
    end
    step(1);
    checks++;
    if (wake_ack_o !== 1'b0) begin errors++; $display("[TB] FAIL wake_c2_ack: got %b expected 0", wake_ack_o); end
    step(1);
    checks++;
    if (wake_ack_o !== 1'b1) begin errors++; $display("[TB] FAIL wake_c3_ack: got %b expected 1", wake_ack_o); end
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      if (wake_ack_o === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0) begin errors++; $display("[TB] FAIL held_req_repulse: got %0d pulses expected 0", pulses); end
    wake_req_i = 1'b0;
    step(1);
    wake_req_i = 1'b1;
    step(1);
    checks++;
    if (wake_ack_o !== 1'b1) begin errors++; $display("[TB] FAIL run_req_ack: got %b expected 1", wake_ack_o); end
    step(1);
    checks++;
    if (wake_ack_o !== 1'b0) begin errors++; $display("[TB] FAIL run_req_single: got %b expected 0", wake_ack_o); end
    wake_req_i = 1'b0;
  endtask

  task automatic test_force();
    reach_gated();
    force_en_i = 1'b1;
    #1;
    checks++;
    if (en_o !== 1'b1 || gated_o !== 1'b1) begin
      errors++; $display("[TB] FAIL force_now: got en=%b gated=%b expected en=1 gated=1", en_o, gated_o);
    end
    step(3);
    checks++;
    if (en_o !== 1'b1 || gated_o !== 1'b1 || gated_cycles_o !== stat_exp(32'd3)) begin
      errors++; $display("[TB] FAIL force_hold: got en=%b gated=%b cnt=%0d expected 1 1 %0d",
                         en_o, gated_o, gated_cycles_o, stat_exp(32'd3));
    end
    force_en_i = 1'b0;
    #1;
    checks++;
    if (en_o !== 1'b0) begin errors++; $display("[TB] FAIL force_release: got en=%b expected 0", en_o); end
  endtask

  task automatic test_cg_disable();
    int bad;
    reach_gated();
    cg_enable_i = 1'b0;
    step(1);
    checks++;
    if (en_o !== 1'b1 || gated_o !== 1'b0) begin
      errors++; $display("[TB] FAIL cgdis_wake: got en=%b gated=%b expected 1 0", en_o, gated_o);
    end
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (en_o !== 1'b1 || gated_o !== 1'b0 || wake_ack_o !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("[TB] FAIL cgdis_hold: got %0d bad cycles expected 0", bad); end
    cg_enable_i = 1'b1;
    step(15);
    checks++;
    if (en_o !== 1'b1) begin errors++; $display("[TB] FAIL cgen_idle15: got en=%b expected 1", en_o); end
    step(1);
    checks++;
    if (en_o !== 1'b0) begin errors++; $display("[TB] FAIL cgen_regate: got en=%b expected 0", en_o); end
  endtask

  task automatic test_reset_in_gated();
    reach_gated();
    step(2);
    rst_i = 1'b1;
    step(1);
    checks++;
    if (en_o !== 1'b1 || gated_o !== 1'b0 || gated_cycles_o !== 32'd0) begin
      errors++; $display("[TB] FAIL rst_gated: got en=%b gated=%b cnt=%0d expected 1 0 0", en_o, gated_o, gated_cycles_o);
    end
    rst_i = 1'b0;
    reach_gated();
    busy_i = 1'b1;
    step(1);
    rst_i = 1'b1;
    step(1);
    rst_i = 1'b0;
    busy_i = 1'b0;
    step(15);
    checks++;
    if (en_o !== 1'b1 || wake_ack_o !== 1'b0) begin
      errors++; $display("[TB] FAIL rst_wake_run: got en=%b ack=%b expected 1 0", en_o, wake_ack_o);
    end
    step(1);
    checks++;
    if (gated_o !== 1'b1) begin errors++; $display("[TB] FAIL rst_wake_regate: got gated=%b expected 1", gated_o); end
  endtask

  task automatic test_stats();
    reach_gated();
`ifdef STRELA_CG_STATS_EN
    dut.u_stats.count_q = 32'hFFFF_FFFF;
    step(1);
    checks++;
    if (gated_cycles_o !== 32'd0) begin errors++; $display("[TB] FAIL stats_wrap: got %0h expected 0", gated_cycles_o); end
`endif
    step(2);
    stats_clr_i = 1'b1;
    step(1);
    checks++;
    if (gated_cycles_o !== 32'd0) begin errors++; $display("[TB] FAIL stats_clr: got %0d expected 0", gated_cycles_o); end
    stats_clr_i = 1'b0;
    step(2);
    checks++;
    if (gated_cycles_o !== stat_exp(32'd2)) begin
      errors++; $display("[TB] FAIL stats_after_clr: got %0d expected %0d", gated_cycles_o, stat_exp(32'd2));
    end
  endtask

  initial begin
    $display("[TB] start (stats build = %0d)", STATS);
    test_reset();
    test_idle_gating();
    test_threshold_override();
    test_wake_request();
    test_force();
    test_cg_disable();
    test_reset_in_gated();
    test_stats();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/strela_clk_gate_ctrl.md
STRELA_CLK_GATE_CTRL -- requirements
Module: strela_clk_gate_ctrl

Interface
REQ-001 Parameter IDLE_CYCLES, default 16: consecutive idle cycles in RUN before gating; 0 disables gating.
REQ-002 Parameter WAKE_CYCLES, default 2: settle cycles after re-enable before RUN; legal range >= 1.
REQ-003 clk_i  in  1  the only clock, free-running, ungated domain.
REQ-004 rst_i  in  1  reset, synchronous to clk_i, active-high.
REQ-005 cg_enable_i  in  1  gating allowed when 1; when 0 the CGRA clock stays on.
REQ-006 force_en_i  in  1  test/scan override; forces en_o=1.
REQ-007 busy_i  in  1  CGRA activity, sampled in the ungated domain.
REQ-008 wake_req_i  in  1  level request from the host side; held high until wake_ack_o.
REQ-009 wake_ack_o  out  1  one-cycle pulse; the gated clock is running and stable.
REQ-010 en_o  out  1  enable to the downstream clock gate en_i.
REQ-011 gated_o  out  1  status; 1 while in GATED.
REQ-012 gated_cycles_o  out  32  count of cycles with en_q=0 (see Configuration).
REQ-013 stats_clr_i  in  1  synchronous clear of gated_cycles_o.

Function
REQ-014 The FSM SHALL have states RUN, GATED and WAKE; en_q SHALL be a register, and en_o SHALL equal en_q OR force_en_i.
REQ-015 RUN: en_q=1; the idle counter increments when busy_i=0 and wake_req_i=0 and cg_enable_i=1, else clears to 0; counter width is clog2(IDLE_CYCLES+1), saturating.
REQ-016 RUN->GATED when the counter equals IDLE_CYCLES-1 and the current cycle is idle; en_q=0 from the next cycle; 0 disables the transition.
REQ-017 Busy_i or wake_req_i in the threshold cycle SHALL win: the FSM stays in RUN and the counter clears.
REQ-018 GATED: en_q=0 and gated_o=1; any of busy_i, wake_req_i or !cg_enable_i SHALL move the FSM to WAKE with en_q=1 next cycle.
REQ-019 WAKE: en_q=1; the FSM counts WAKE_CYCLES cycles then enters RUN with the idle counter at 0; events in WAKE SHALL NOT abort it.
REQ-020 wake_ack_o SHALL pulse one cycle after wake_req_i is sampled high in RUN.
REQ-021 A request arriving in GATED or WAKE SHALL be acknowledged on the first RUN cycle.
REQ-022 wake_ack_o SHALL NOT re-pulse until wake_req_i has been sampled low at least once.
REQ-023 force_en_i SHALL NOT alter FSM state or counters.
REQ-024 End-to-end latency: GATED wake event to en_o=1 is 1 cycle; wake event to wake_ack_o is WAKE_CYCLES+1 cycles.

Reset
REQ-025 rst_i=1 SHALL set state RUN, en_q=1, idle counter 0, wake_ack_o=0, gated_o=0, gated_cycles_o=0, and the ack-armed flag set.
REQ-026 Reset asserted in GATED or WAKE SHALL take effect on the next edge, making en_o=1 with no intermediate state.

Configuration
REQ-027 Macro STRELA_CG_STATS_EN defined: gated_cycles_o increments each cycle en_q=0 and wraps from 2^32-1 to 0; stats_clr_i has priority over increment.
REQ-028 Macro STRELA_CG_STATS_EN undefined: gated_cycles_o is tied to 0, stats_clr_i is ignored, and no counter flops are present.

Structure
REQ-029 Package strela_cg_pkg SHALL hold the state enum typedef and the default IDLE_CYCLES and WAKE_CYCLES constants.
REQ-030 Sub-module strela_cg_stats SHALL hold the 32-bit counter, instantiated only under STRELA_CG_STATS_EN.
REQ-031 The FSM and idle counter SHALL remain inline.

Verification
REQ-032 Reset, then busy_i=0 for 16 cycles -> en_o falls on cycle 17 and gated_o=1.
REQ-033 busy_i pulse on idle cycle 16 -> FSM stays RUN, counter=0, en_o stays 1.
REQ-034 Request raised in GATED -> en_o=1 after 1 cycle, wake_ack_o pulses at cycle 3 (WAKE_CYCLES=2), then one pulse only while the request is held.
REQ-035 force_en_i=1 in GATED -> en_o=1, gated_o=1 unchanged; gated_cycles_o still increments under the macro.
REQ-036 cg_enable_i=0 in GATED -> WAKE then RUN; no gating while it stays 0.
REQ-037 Counter preloaded to 0xFFFFFFFF, one gated cycle -> 0; stats_clr_i with en_q=0 -> 0.
